reg_read_unit: RTL and testbench

Parametrised, pipelined register-operand fetch stage for the ARM datapath. It generalises the single-port Rn/R15 address select into NPORTS read ports. Each port has its own address-source select, and the unit includes the architectural register storage, PC+offset substitution for R15, and same-cycle writeback bypass. Results are registered behind a valid/ready handshake, so the stage sits between decode and execute in the pipelined core.

---
 rtl/reg_read_unit.sv | 91 +++++++++
 tb/tb_reg_read_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_read_unit.sv
// reg_read_unit: multi-port register operand fetch with PC substitution, writeback bypass and
// a registered valid/ready output whose held operands track writeback during stalls.
module reg_read_unit #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 16,
    parameter int ADDR_W    = 4,
    parameter int NPORTS    = 3,
    parameter int PC_OFFSET = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NPORTS*ADDR_W-1:0] rf_addr,
    input  logic [NPORTS*2-1:0]      src_sel,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPORTS*DATA_W-1:0] rd_data,
    output logic [NPORTS*ADDR_W-1:0] rd_addr
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] LR_IDX = ADDR_W'(NREG - 2);

    logic [DATA_W-1:0]             mem_q [NREG-1];
    logic                          out_valid_q, out_valid_d;
    logic [NPORTS-1:0][DATA_W-1:0] rd_data_q, rd_data_d, val;
    logic [NPORTS-1:0][ADDR_W-1:0] rd_addr_q, rd_addr_d, idx;
    logic [NPORTS-1:0]             st_q, st_d, cz;
    logic                          wr_ok, accept;

    assign wr_ok     = we && (wa < PC_IDX);
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_addr   = rd_addr_q;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            idx[p] = src_sel[2*p +: 2] == 2'b00 ? rf_addr[p*ADDR_W +: ADDR_W] :
                     src_sel[2*p +: 2] == 2'b01 ? PC_IDX :
                     src_sel[2*p +: 2] == 2'b10 ? LR_IDX : '0;
            cz[p]  = src_sel[2*p +: 2] == 2'b11;
            val[p] = cz[p]                   ? '0 :
                     idx[p] == PC_IDX        ? pc + DATA_W'(PC_OFFSET) :
                     wr_ok && wa == idx[p]   ? wd :
                     idx[p] < PC_IDX         ? mem_q[idx[p]] : '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rd_data_d   = rd_data_q;
        rd_addr_d   = rd_addr_q;
        st_d        = st_q;
        if (accept) begin
            out_valid_d = 1'b1;
            for (int p = 0; p < NPORTS; p++) begin
                rd_data_d[p] = val[p];
                rd_addr_d[p] = idx[p];
                st_d[p]      = !cz[p] && idx[p] < PC_IDX;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wr_ok) begin
            // stalled operands follow writeback so execute never sees a stale value
            for (int p = 0; p < NPORTS; p++)
                if (st_q[p] && rd_addr_q[p] == wa) rd_data_d[p] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            st_q        <= '0;
            for (int i = 0; i < NREG - 1; i++) mem_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_data_q   <= rd_data_d;
            rd_addr_q   <= rd_addr_d;
            st_q        <= st_d;
            if (wr_ok) mem_q[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_reg_read_unit.sv
// tb_reg_read_unit: directed table, hand sequences and random traffic against a storage-array model.
module tb_reg_read_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, we, out_valid, out_ready;
    logic [11:0] rf_addr, rd_addr;
    logic [5:0]  src_sel;
    logic [31:0] pc, wd;
    logic [3:0]  wa;
    logic [95:0] rd_data;

    int checks = 0, errors = 0;

    logic [31:0] m_mem [16];
    logic        m_v;
    logic [31:0] m_d [3];
    logic [3:0]  m_a [3];
    logic        m_st [3];

    typedef struct {
        logic [1:0]  s;
        logic [3:0]  a;
        logic [31:0] pc;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [31:0] ed;
        logic [3:0]  ea;
    } vec_t;
    vec_t tv [10];

    reg_read_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rf_addr(rf_addr), .src_sel(src_sel), .pc(pc), .we(we), .wa(wa), .wd(wd),
        .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // model: a write lands first, then every storage read sees the updated array
    task automatic tick();
        logic [31:0] nm [16];
        logic [95:0] ed;
        logic [11:0] ea;
        logic [3:0]  ix;
        #1;
        chk("in_ready", in_ready, !m_v || out_ready);
        nm = m_mem;
        if (we && wa != 4'd15) nm[wa] = wd;
        if (reset) begin
            for (int i = 0; i < 16; i++) nm[i] = 0;
            m_v = 0;
            for (int p = 0; p < 3; p++) begin m_d[p] = 0; m_a[p] = 0; m_st[p] = 0; end
        end else if (in_valid && (!m_v || out_ready)) begin
            m_v = 1;
            for (int p = 0; p < 3; p++) begin
                case (src_sel[2*p +: 2])
                    2'd0: ix = rf_addr[4*p +: 4];
                    2'd1: ix = 4'd15;
                    2'd2: ix = 4'd14;
                    default: ix = 4'd0;
                endcase
                m_a[p]  = ix;
                m_st[p] = src_sel[2*p +: 2] != 2'd3 && ix != 4'd15;
                m_d[p]  = src_sel[2*p +: 2] == 2'd3 ? 32'd0 : ix == 4'd15 ? pc + 32'd8 : nm[ix];
            end
        end else if (out_ready) begin
            m_v = 0;
        end else if (m_v) begin
            for (int p = 0; p < 3; p++) if (m_st[p]) m_d[p] = nm[m_a[p]];
        end
        m_mem = nm;
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin ed[32*p +: 32] = m_d[p]; ea[4*p +: 4] = m_a[p]; end
        chk("out_valid", out_valid, m_v);
        chk("rd_data", rd_data, ed);
        chk("rd_addr", rd_addr, ea);
    endtask

    initial begin
        tv[0] = '{2'b01, 4'd0,  32'h0000_1000, 1'b0, 4'd0,  32'h0,      32'h0000_1008, 4'd15};
        tv[1] = '{2'b01, 4'd0,  32'hFFFF_FFFC, 1'b0, 4'd0,  32'h0,      32'h0000_0004, 4'd15};
        tv[2] = '{2'b01, 4'd0,  32'h0000_2000, 1'b1, 4'd15, 32'hDEAD,   32'h0000_2008, 4'd15};
        tv[3] = '{2'b00, 4'd15, 32'h0000_0010, 1'b0, 4'd0,  32'h0,      32'h0000_0018, 4'd15};
        tv[4] = '{2'b00, 4'd5,  32'h0,         1'b1, 4'd5,  32'hABCD,   32'h0000_ABCD, 4'd5};
        tv[5] = '{2'b00, 4'd5,  32'h0,         1'b0, 4'd0,  32'h0,      32'h0000_ABCD, 4'd5};
        tv[6] = '{2'b11, 4'd9,  32'h0,         1'b0, 4'd0,  32'h0,      32'h0,         4'd0};
        tv[7] = '{2'b10, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,      32'h0000_0022, 4'd14};
        tv[8] = '{2'b00, 4'd3,  32'h0,         1'b0, 4'd0,  32'h0,      32'h0000_0011, 4'd3};
        tv[9] = '{2'b00, 4'd3,  32'h0,         1'b1, 4'd4,  32'h55,     32'h0000_0011, 4'd3};
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_v = 0;
        for (int p = 0; p < 3; p++) begin m_d[p] = 0; m_a[p] = 0; m_st[p] = 0; end
        reset = 1; in_valid = 0; we = 0; wa = 0; wd = 0; pc = 0; rf_addr = 0; src_sel = 0; out_ready = 1;
        tick(); tick();
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_ready", in_ready, 1'b1);
        reset = 0;
        we = 1; wa = 3; wd = 32'h11; tick();
        wa = 14; wd = 32'h22; tick();
        we = 0;
        in_valid = 1; rf_addr = 12'h003; src_sel = 6'b111000; tick();
        chk("basic_data", rd_data, {32'h0, 32'h22, 32'h11});
        chk("basic_addr", rd_addr, {4'd0, 4'd14, 4'd3});
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            src_sel = {4'b1111, tv[i].s}; rf_addr = {8'h0, tv[i].a}; pc = tv[i].pc;
            we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd; in_valid = 1;
            tick();
            chk($sformatf("vec%0d_data", i), rd_data[31:0], tv[i].ed);
            chk($sformatf("vec%0d_addr", i), rd_addr[3:0], tv[i].ea);
            we = 0; in_valid = 0;
        end
        we = 1; wa = 7; wd = 32'h1; tick();
        we = 0;
        in_valid = 1; rf_addr = 12'h007; src_sel = 6'b011100; pc = 32'h100; out_ready = 0; tick();
        chk("stall_load", rd_data, {32'h108, 32'h0, 32'h1});
        chk("stall_ready", in_ready, 1'b0);
        we = 1; wa = 7; wd = 32'h77; tick();
        chk("stall_refresh", rd_data, {32'h108, 32'h0, 32'h77});
        chk("stall_ready2", in_ready, 1'b0);
        we = 0; tick();
        chk("stall_hold", out_valid, 1'b1);
        out_ready = 1; in_valid = 0; tick();
        chk("single_transfer", out_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; rf_addr = 12'(i); src_sel = 6'b111100;
            tick();
            chk($sformatf("stream%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("stream%0d_addr", i), rd_addr[3:0], 4'(i));
        end
        in_valid = 0; tick();
        chk("stream_end", out_valid, 1'b0);
        for (int r = 0; r < 15; r++) begin
            we = 1; wa = 4'(r); wd = $urandom | 32'h1; tick();
        end
        we = 0;
        in_valid = 1; rf_addr = 12'h002; src_sel = 6'b111100; out_ready = 0; tick(); tick();
        reset = 1; tick();
        chk("rst_stall_valid", out_valid, 1'b0);
        chk("rst_stall_data", rd_data, 96'h0);
        chk("rst_stall_addr", rd_addr, 12'h0);
        chk("rst_stall_ready", in_ready, 1'b1);
        reset = 0; out_ready = 1;
        for (int r = 0; r < 15; r++) begin
            rf_addr = 12'(r); tick();
            chk($sformatf("rst_reg%0d", r), rd_data[31:0], 32'h0);
        end
        in_valid = 0;
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 59) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            rf_addr = 12'($urandom); src_sel = 6'($urandom);
            pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            we = $urandom_range(0, 1) == 1; wa = 4'($urandom); wd = $urandom;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
